// File: rtl/popcount_rr_sched_if.sv
// Requester/consumer bus for the shared popcount scheduler.
// The master drives requests and result acceptance; the slave grants and returns results.
interface popcount_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int CW   = $clog2(DW) + 1,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               res_valid;
  logic [IDW-1:0]     res_id;
  logic [CW-1:0]      res_count;
  logic               res_ready;

  modport master (
    output req,
    output req_data,
    output res_ready,
    input  gnt,
    input  busy,
    input  res_valid,
    input  res_id,
    input  res_count
  );

  modport slave (
    input  req,
    input  req_data,
    input  res_ready,
    output gnt,
    output busy,
    output res_valid,
    output res_id,
    output res_count
  );
endinterface

// File: rtl/popcount_rr_sched.sv
// Round-robin shared popcount unit: grant, count, then hold the tagged result.
// One operation per three cycles when the consumer is always ready.
module popcount_rr_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int CW   = $clog2(DW) + 1,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic clk,
  input logic rst_n,
  popcount_rr_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    OUT   = 2'b10
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  tag_q;
  logic [DW-1:0]   operand_q;
  logic [NREQ-1:0] gnt_q;
  logic            res_valid_q;
  logic [IDW-1:0]  res_id_q;
  logic [CW-1:0]   res_count_q;

  logic [IDW-1:0]  win_d;
  logic            found_d;
  logic [CW-1:0]   pop_d;
  logic [IDW-1:0]  ptr_d;

  // Pick the first active requester at or after the pointer.
  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found_d && bus.req[idx]) begin
        found_d = 1'b1;
        win_d   = IDW'(idx);
      end
    end
  end

  // Bit count of the captured operand.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < DW; i++) begin
      pop_d = pop_d + CW'(operand_q[i]);
    end
  end

  // Pointer moves just past the requester that was served.
  always_comb begin
    ptr_d = (tag_q == IDW'(NREQ - 1)) ? '0 : tag_q + 1'b1;
  end

  // Sequencer: load on grant, count, then hold until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      tag_q       <= '0;
      operand_q   <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          gnt_q <= '0;
          if (found_d) begin
            operand_q <= bus.req_data[win_d*DW +: DW];
            tag_q     <= win_d;
            gnt_q     <= {{(NREQ-1){1'b0}}, 1'b1} << win_d;
            state_q   <= COUNT;
          end
        end
        COUNT: begin
          gnt_q       <= '0;
          res_count_q <= pop_d;
          res_id_q    <= tag_q;
          res_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          gnt_q <= '0;
          if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          gnt_q       <= '0;
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_count = res_count_q;

endmodule
